// File: rtl/sca_sequencer.sv
// Sequencer: loads cfg serially, pulses flip clock, captures and unloads the scan chain into result.
// Latency: done is high in cycle T0+1+L, where L = 2*CFG_LEN + 2*flip_count + 2 + 2*CAP_LEN.
// Backpressure: none; start is sampled only in IDLE, and a start in any other state is dropped.
// Ports: sca_clk/sca_reset (async active-low); start, cfg, flip_count (request);
//   busy, done, result (status); rx_sclk, rx_sda (serial receiver); flip_out (DUT flip clock);
//   so_clk, so_en, so_data (output scan chain). Every output is a flop.
module sca_sequencer #(
  parameter int CFG_LEN = 16,
  parameter int CAP_LEN = 8,
  parameter int FLIP_W  = 8
) (
  input  logic               sca_clk,
  input  logic               sca_reset,
  input  logic               start,
  input  logic [CFG_LEN-1:0] cfg,
  input  logic [FLIP_W-1:0]  flip_count,
  output logic               busy,
  output logic               done,
  output logic [CAP_LEN-1:0] result,
  output logic               rx_sclk,
  output logic               rx_sda,
  output logic               flip_out,
  output logic               so_clk,
  output logic               so_en,
  input  logic               so_data
);

  // One counter serves every state. It is wide enough for the largest bit index
  // and for a full 2^FLIP_W-1 period count.
  localparam int CFG_CW  = $clog2(CFG_LEN) + 1;
  localparam int CAP_CW  = $clog2(CAP_LEN) + 1;
  localparam int FLIP_CW = FLIP_W + 1;
  localparam int CNT_A   = (CFG_CW > CAP_CW) ? CFG_CW : CAP_CW;
  localparam int CNT_W   = (CNT_A > FLIP_CW) ? CNT_A : FLIP_CW;

  localparam logic [CNT_W-1:0] CFG_LAST = CNT_W'(CFG_LEN - 1);
  localparam logic [CNT_W-1:0] CAP_LAST = CNT_W'(CAP_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_FLIP    = 3'd2,
    S_CAPTURE = 3'd3,
    S_UNLOAD  = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic               phase_q, phase_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CFG_LEN-1:0] cfg_q, cfg_d;     // shifts left; the MSB is the bit on rx_sda
  logic [FLIP_W-1:0]  flip_q, flip_d;
  logic [CAP_LEN-1:0] result_q, result_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               rx_sclk_q, rx_sclk_d;
  logic               rx_sda_q, rx_sda_d;
  logic               flip_out_q, flip_out_d;
  logic               so_clk_q, so_clk_d;
  logic               so_en_q, so_en_d;
  logic [CNT_W-1:0]   flip_last;

  // This value is used only in FLIP, where flip_q is nonzero, so the subtraction cannot underflow.
  assign flip_last = CNT_W'(flip_q) - CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    cfg_d    = cfg_q;
    flip_d   = flip_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_LOAD;
          phase_d  = 1'b0;
          cnt_d    = '0;
          cfg_d    = cfg;
          flip_d   = flip_count;
          result_d = '0;
        end
      end
      S_LOAD: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          cfg_d = {cfg_q[CFG_LEN-2:0], 1'b0};
          if (cnt_q == CFG_LAST) begin
            cnt_d   = '0;
            state_d = (flip_q == '0) ? S_CAPTURE : S_FLIP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_FLIP: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          if (cnt_q == flip_last) begin
            cnt_d   = '0;
            state_d = S_CAPTURE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_CAPTURE: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          cnt_d   = '0;
          state_d = S_UNLOAD;
        end
      end
      S_UNLOAD: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          if (cnt_q == CAP_LAST) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        phase_d = 1'b0;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        phase_d = 1'b0;
        cnt_d   = '0;
      end
    endcase

    // Outputs are derived from the next state, so each flop shows the state it belongs to
    // during that state's own cycle.
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    rx_sclk_d  = (state_d == S_LOAD) && !phase_d;
    rx_sda_d   = (state_d == S_LOAD) ? cfg_d[CFG_LEN-1] : 1'b0;
    flip_out_d = (state_d == S_FLIP) && !phase_d;
    so_clk_d   = ((state_d == S_CAPTURE) || (state_d == S_UNLOAD)) && !phase_d;
    so_en_d    = (state_d == S_UNLOAD);

    // The top bit is sampled on entry to each UNLOAD phase 0. At that point one full cycle
    // has passed since the last so_clk falling edge, so the chain has settled.
    if ((state_d == S_UNLOAD) && !phase_d) begin
      result_d = {result_q[CAP_LEN-2:0], so_data};
    end
  end

  always_ff @(posedge sca_clk or negedge sca_reset) begin
    if (!sca_reset) begin
      state_q    <= S_IDLE;
      phase_q    <= 1'b0;
      cnt_q      <= '0;
      cfg_q      <= '0;
      flip_q     <= '0;
      result_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rx_sclk_q  <= 1'b0;
      rx_sda_q   <= 1'b0;
      flip_out_q <= 1'b0;
      so_clk_q   <= 1'b0;
      so_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      cfg_q      <= cfg_d;
      flip_q     <= flip_d;
      result_q   <= result_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rx_sclk_q  <= rx_sclk_d;
      rx_sda_q   <= rx_sda_d;
      flip_out_q <= flip_out_d;
      so_clk_q   <= so_clk_d;
      so_en_q    <= so_en_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign rx_sclk  = rx_sclk_q;
  assign rx_sda   = rx_sda_q;
  assign flip_out = flip_out_q;
  assign so_clk   = so_clk_q;
  assign so_en    = so_en_q;

endmodule

// File: tb/tb_sca_sequencer.sv
// Bench for sca_sequencer: negedge serial receiver, XOR-pattern DUT and negedge scan chain.
// Expected results come from the sequence-level rules: receiver holds cfg, flip parity selects mux.
// Drives inputs on falling clock edges and samples outputs on falling clock edges.
module tb_sca_sequencer;
  localparam int CFG_LEN = 16;
  localparam int CAP_LEN = 8;
  localparam int FLIP_W  = 8;

  logic               sca_clk = 1'b0;
  logic               sca_reset = 1'b0;
  logic               start = 1'b0;
  logic [CFG_LEN-1:0] cfg = '0;
  logic [FLIP_W-1:0]  flip_count = '0;
  logic               busy, done, rx_sclk, rx_sda, flip_out, so_clk, so_en, so_data;
  logic [CAP_LEN-1:0] result;

  int vectors = 0;
  int miscompares = 0;

  sca_sequencer #(.CFG_LEN(CFG_LEN), .CAP_LEN(CAP_LEN), .FLIP_W(FLIP_W)) dut (
    .sca_clk(sca_clk), .sca_reset(sca_reset), .start(start), .cfg(cfg),
    .flip_count(flip_count), .busy(busy), .done(done), .result(result),
    .rx_sclk(rx_sclk), .rx_sda(rx_sda), .flip_out(flip_out), .so_clk(so_clk),
    .so_en(so_en), .so_data(so_data)
  );

  always #5 sca_clk = ~sca_clk;

  // ---------------- environment models ----------------
  logic [CFG_LEN-1:0] rx_sr = '0;
  logic               sel = 1'b0;
  logic [CAP_LEN-1:0] chain = '0;
  logic               override = 1'b0;
  logic [CAP_LEN-1:0] override_val = '0;

  // The DUT has 8 inputs. Input i selects cfg bit 2i or 2i+1, and out[j] = in[j] ^ in[(j+3)%8].
  function automatic logic [7:0] dut_func(input logic [15:0] r, input logic s);
    logic [7:0] in_v, out_v;
    for (int i = 0; i < 8; i++) in_v[i] = s ? r[2*i+1] : r[2*i];
    for (int j = 0; j < 8; j++) out_v[j] = in_v[j] ^ in_v[(j+3)%8];
    return out_v;
  endfunction

  // Reference: after a run the receiver holds c, and an odd flip count leaves the mux on the odd bits.
  function automatic logic [7:0] ref_result(input logic [15:0] c, input int f);
    return dut_func(c, (f % 2) == 1);
  endfunction

  always @(negedge rx_sclk) begin
    rx_sr = {rx_sr[CFG_LEN-2:0], rx_sda};
    sel = 1'b0;
  end
  always @(posedge flip_out) sel = ~sel;

  wire [CAP_LEN-1:0] par_in = override ? override_val : dut_func(rx_sr, sel);
  always @(negedge so_clk) begin
    if (!so_en) chain = par_in;
    else        chain = {chain[CAP_LEN-2:0], 1'b0};
  end
  assign so_data = chain[CAP_LEN-1];

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Run one transaction. Every cycle through the expected done cycle is observed.
  task automatic run_one(input logic [15:0] c, input int f, input logic ov,
                         input logic [7:0] ovv, input string tag);
    int L, done_at, pulses, bad_flip, busy_bad;
    logic [15:0] rx_at_done;
    logic [7:0] res_at_done;
    L = 2*CFG_LEN + 2*f + 2 + 2*CAP_LEN;
    done_at = -1; pulses = 0; bad_flip = 0; busy_bad = 0;
    rx_at_done = '0; res_at_done = '0;
    @(negedge sca_clk);
    override = ov; override_val = ovv;
    cfg = c; flip_count = FLIP_W'(f); start = 1'b1;
    for (int n = 1; n <= L + 1; n++) begin
      @(negedge sca_clk);
      if (n == 1) begin
        start = 1'b0; cfg = 16'($urandom); flip_count = 8'($urandom);
      end
      if (flip_out) pulses++;
      if (flip_out && (so_clk || so_en)) bad_flip++;
      if (n <= L && (!busy || done)) busy_bad++;
      if (done && done_at < 0) begin
        done_at = n; rx_at_done = rx_sr; res_at_done = result;
      end
    end
    check({tag, " done_cycle"}, done_at, L + 1);
    check({tag, " flip_pulses"}, pulses, f);
    check({tag, " flip_in_capture"}, bad_flip, 0);
    check({tag, " busy_window"}, busy_bad, 0);
    check({tag, " rx_contents"}, rx_at_done, c);
    check({tag, " result"}, res_at_done, ov ? ovv : ref_result(c, f));
    @(negedge sca_clk);
    check({tag, " idle_after_done"}, {busy, done}, 2'b00);
    check({tag, " result_held"}, result, ov ? ovv : ref_result(c, f));
    override = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f, L, P, seen, exp_dones, idx, done_cnt, rst_cycle;
    logic [15:0] c;
    logic [15:0] hist [0:399];

    // Reset state
    repeat (3) @(negedge sca_clk);
    check("reset_outputs", {busy, done, rx_sclk, rx_sda, flip_out, so_clk, so_en}, 7'd0);
    check("reset_result", result, 8'h00);
    sca_reset = 1'b1;
    repeat (2) @(negedge sca_clk);

    // Directed cases
    run_one(16'hA5C3, 3, 1'b0, 8'h00, "a5c3_f3");
    run_one(16'h3C96, 0, 1'b0, 8'h00, "f0");
    run_one(16'h1234, 2, 1'b1, 8'h81, "msb_order");
    run_one(16'($urandom), 255, 1'b0, 8'h00, "f255");

    // Random cases
    for (int k = 0; k < 4; k++) begin
      run_one(16'($urandom), $urandom_range(0, 20), 1'b0, 8'h00, "rand");
    end

    // Start is held high for 200 edges while cfg changes every cycle.
    f = $urandom_range(0, 4);
    L = 2*CFG_LEN + 2*f + 2 + 2*CAP_LEN;
    P = L + 2;
    exp_dones = (199 / P) + 1;
    for (int i = 0; i < 400; i++) hist[i] = 16'($urandom);
    @(negedge sca_clk);
    cfg = hist[0]; flip_count = FLIP_W'(f); start = 1'b1;
    seen = 0;
    for (int n = 1; n < 400; n++) begin
      @(negedge sca_clk);
      if (done) begin
        seen++;
        idx = (seen - 1) * P;
        if (idx > 399) idx = 0;
        check("b2b done_cycle", n, idx + L + 1);
        check("b2b rx_contents", rx_sr, hist[idx]);
        check("b2b result", result, ref_result(hist[idx], f));
      end
      start = (n < 200);
      cfg = hist[n];
    end
    check("b2b done_count", seen, exp_dones);

    // Reset asserted in UNLOAD bit 3 (phase 0)
    f = $urandom_range(1, 5);
    c = 16'($urandom);
    rst_cycle = 2*CFG_LEN + 2*f + 3 + 6;
    @(negedge sca_clk);
    cfg = c; flip_count = FLIP_W'(f); start = 1'b1;
    for (int n = 1; n < rst_cycle; n++) begin
      @(negedge sca_clk);
      start = 1'b0;
    end
    @(negedge sca_clk);
    check("pre_reset unload", {so_en, so_clk, busy}, 3'b111);
    sca_reset = 1'b0;
    #1;
    check("reset_mid outputs", {busy, done, rx_sclk, rx_sda, flip_out, so_clk, so_en}, 7'd0);
    check("reset_mid result", result, 8'h00);
    done_cnt = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge sca_clk);
      if (done) done_cnt++;
      if (n == 3) sca_reset = 1'b1;
    end
    check("reset_mid no_done", done_cnt, 0);
    check("reset_mid idle", busy, 1'b0);
    run_one(16'($urandom), $urandom_range(0, 6), 1'b0, 8'h00, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
